eeg_ingest_writer: RTL and testbench

//  Producer end of the EEG_INPUT_MEM region of intermediate-result memory. Accepts one 16b unsigned
//  ADC sample per valid/ready beat and converts it to double-width fixed point (IntResDouble_t).

---
 rtl/eeg_ingest_writer_if.sv | 46 ++++
 rtl/eeg_ingest_writer.sv | 209 ++++++++++++++++++++
 tb/tb_eeg_ingest_writer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eeg_ingest_writer_if.sv
// ---------------------------------------------------------------------------
// eeg_ingest_writer_if
// Bundles the ADC sample stream (valid/ready) and the int-res memory write
// request channel (req/gnt with address, data and width). The writer uses the
// master modport; the environment (ADC source plus memory arbiter) uses the
// slave modport.
// ---------------------------------------------------------------------------
interface eeg_ingest_writer_if;

  // ADC sample stream (AdcData_t)
  logic [15:0] adc_data;
  logic        adc_valid;
  logic        adc_ready;

  // int-res memory write channel
  logic        mem_wr_req;
  logic        mem_wr_gnt;
  logic [15:0] mem_wr_addr;   // IntResAddr_t
  logic [15:0] mem_wr_data;   // IntResDouble_t
  logic        mem_wr_width;  // DataWidth_t

  // Writer side: consumes samples, issues memory writes
  modport master (
    input  adc_data,
    input  adc_valid,
    output adc_ready,
    output mem_wr_req,
    input  mem_wr_gnt,
    output mem_wr_addr,
    output mem_wr_data,
    output mem_wr_width
  );

  // Environment side: produces samples, grants memory writes
  modport slave (
    output adc_data,
    output adc_valid,
    input  adc_ready,
    input  mem_wr_req,
    output mem_wr_gnt,
    input  mem_wr_addr,
    input  mem_wr_data,
    input  mem_wr_width
  );

endinterface

// File: rtl/eeg_ingest_writer.sv
// ---------------------------------------------------------------------------
// eeg_ingest_writer
// Producer end of the EEG input region of intermediate-result memory. Each
// accepted 16b unsigned ADC sample is re-centred around zero, optionally
// scaled down by an arithmetic shift, and written as a double-width value to
// consecutive addresses starting at BASE_ADDR. After NUM_SAMPLES writes have
// been granted a one-cycle done pulse is raised.
//
// A single capture register sits between the ADC stream and the memory
// request. A grant frees that register in the same cycle, so with the
// arbiter granting every cycle the block sustains one sample per clock.
// ---------------------------------------------------------------------------
module eeg_ingest_writer #(
  parameter int          NUM_SAMPLES  = 3840,     // samples per epoch
  parameter logic [15:0] BASE_ADDR    = 16'h0000, // first write address
  parameter int          SAMPLE_SHIFT = 0         // 0..8, applied after offset removal
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  eeg_ingest_writer_if.master        bus,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_overrun
);

  // count has to represent NUM_SAMPLES itself after the final capture
  localparam int                CNT_W        = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX     = CNT_W'(NUM_SAMPLES - 1);
  localparam logic              DOUBLE_WIDTH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State registers and their next-state values
  // -------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_next;
  logic               r_pending;
  logic               w_pending_next;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_next;
  logic [15:0]        r_addr;
  logic [15:0]        w_addr_next;
  logic [15:0]        r_data;
  logic [15:0]        w_data_next;
  logic               r_done;
  logic               w_done_next;
  logic               r_overrun;
  logic               w_overrun_next;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic               w_grant;        // outstanding write accepted by arbiter
  logic               w_slot_free;    // capture register free (or freed this cycle)
  logic               w_ready_base;   // LOAD state with a free slot
  logic               w_ready;        // what the ADC side actually sees
  logic               w_capture;      // sample taken this cycle
  logic               w_start_ok;     // start accepted (IDLE, no abort)
  logic               w_last_capture; // capture of the final sample of the epoch
  logic               w_final_grant;  // grant of the final write of the epoch
  logic               w_stall;        // ADC offered data while we could not take it

  // A grant only counts while a request is outstanding
  assign w_grant      = r_pending & bus.mem_wr_gnt;
  assign w_slot_free  = ~r_pending | bus.mem_wr_gnt;
  assign w_ready_base = (r_state == ST_LOAD) & w_slot_free;

  // abort wins over a same-cycle capture, so the source must not see ready
  assign w_ready        = w_ready_base & ~i_abort;
  assign w_capture      = bus.adc_valid & w_ready;
  assign w_start_ok     = (r_state == ST_IDLE) & i_start & ~i_abort;
  assign w_last_capture = w_capture & (r_count == LAST_IDX);
  assign w_final_grant  = (r_state == ST_DRAIN) & w_grant;

  // Overrun looks at the un-gated ready: a sample refused only because of
  // abort is a deliberate discard, not a back-pressure loss.
  assign w_stall        = o_busy & bus.adc_valid & ~w_ready_base;

  // -------------------------------------------------------------------------
  // Sample conversion: flip the MSB to turn offset-binary into two's
  // complement (adc - 32768), then scale with an arithmetic shift.
  // -------------------------------------------------------------------------
  logic signed [15:0] w_centred;
  logic signed [15:0] w_scaled;

  assign w_centred = $signed({~bus.adc_data[15], bus.adc_data[14:0]});
  assign w_scaled  = w_centred >>> SAMPLE_SHIFT;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: abort returns to IDLE from anywhere and beats start
  always_comb begin
    w_state_next = r_state;
    if (i_abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_next = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_last_capture) begin
            w_state_next = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_grant) begin
            w_state_next = ST_IDLE;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath next values: capture slot, counter, address/data, status flags
  always_comb begin
    w_pending_next = r_pending;
    w_count_next   = r_count;
    w_addr_next    = r_addr;
    w_data_next    = r_data;
    w_done_next    = 1'b0;
    w_overrun_next = r_overrun;

    // Capture slot: a new beat re-arms it even if the old one was granted
    if (i_abort) begin
      w_pending_next = 1'b0;
    end else if (w_capture) begin
      w_pending_next = 1'b1;
    end else if (w_grant) begin
      w_pending_next = 1'b0;
    end

    // Counter is kept across abort so it stays observable until the next start
    if (w_start_ok) begin
      w_count_next = '0;
    end else if (w_capture) begin
      w_count_next = r_count + 1'b1;
    end

    // Address and data only change on capture, so they hold during req & ~gnt
    if (w_capture) begin
      w_addr_next = BASE_ADDR + 16'(r_count);
      w_data_next = w_scaled;
    end

    // An aborted epoch never reports completion, even if its last write commits
    w_done_next = w_final_grant & ~i_abort;

    if (w_start_ok) begin
      w_overrun_next = 1'b0;
    end else if (w_stall) begin
      w_overrun_next = 1'b1;
    end
  end

  // Datapath and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_count   <= '0;
      r_addr    <= BASE_ADDR;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_count   <= w_count_next;
      r_addr    <= w_addr_next;
      r_data    <= w_data_next;
      r_done    <= w_done_next;
      r_overrun <= w_overrun_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.adc_ready    = w_ready;
  assign bus.mem_wr_req   = r_pending;
  assign bus.mem_wr_addr  = r_addr;
  assign bus.mem_wr_data  = r_data;
  assign bus.mem_wr_width = DOUBLE_WIDTH;

  assign o_busy    = (r_state == ST_LOAD) | (r_state == ST_DRAIN);
  assign o_done    = r_done;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_eeg_ingest_writer.sv
// ---------------------------------------------------------------------------
// tb_eeg_ingest_writer
// Two writers run in lockstep on the same stimulus: one with SAMPLE_SHIFT=0
// and one with SAMPLE_SHIFT=4. Accepted samples are queued with their
// expected address and converted values; every granted write pops and
// compares. A short conversion table is checked directly, and hand-written
// sequences cover grant stalls, abort and reset in the middle of an epoch.
// ---------------------------------------------------------------------------
module tb_eeg_ingest_writer;

  localparam int N = 3840;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy0, done0, ovr0;
  logic busy4, done4, ovr4;

  eeg_ingest_writer_if bus ();
  eeg_ingest_writer_if bus4 ();

  assign bus4.adc_data   = bus.adc_data;
  assign bus4.adc_valid  = bus.adc_valid;
  assign bus4.mem_wr_gnt = bus.mem_wr_gnt;

  always #5 clk = ~clk;

  eeg_ingest_writer #(.NUM_SAMPLES(N), .BASE_ADDR(16'h0000), .SAMPLE_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .bus(bus),
    .o_busy(busy0), .o_done(done0), .o_overrun(ovr0)
  );

  eeg_ingest_writer #(.NUM_SAMPLES(N), .BASE_ADDR(16'h0000), .SAMPLE_SHIFT(4)) dut4 (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .bus(bus4),
    .o_busy(busy4), .o_done(done4), .o_overrun(ovr4)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] d0;
    logic [15:0] d4;
  } exp_t;

  typedef struct {
    logic [15:0] adc;
    logic [15:0] exp0;
    logic [15:0] exp4;
  } vec_t;

  exp_t        q[$];
  vec_t        vecs[7];
  int          checks = 0;
  int          failures = 0;
  int          done_count = 0;
  int          wr_count = 0;
  int          exp_addr = 0;
  logic        prev_last_wr = 1'b0;
  logic [15:0] cur_adc = 16'h0;
  logic [15:0] last_acc = 16'h0;
  logic [15:0] tb_exp0 = 16'h0;
  logic [15:0] tb_exp4 = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] conv(input logic [15:0] x, input int sh);
    logic signed [15:0] s;
    s = $signed(x ^ 16'h8000);
    return 16'(s >>> sh);
  endfunction

  // Scoreboard: pop/compare on grant, push on accepted beat
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        exp_addr = 0;
        prev_last_wr = 1'b0;
      end else begin
        if (done0) begin
          done_count++;
          chk("done_after_last_gnt", prev_last_wr, 1);
        end
        prev_last_wr = 1'b0;
        if (bus.mem_wr_req && bus.mem_wr_gnt) begin
          wr_count++;
          if (q.size() == 0) begin
            chk("write_expected", 0, 1);
          end else begin
            e = q.pop_front();
            chk("wr_addr", bus.mem_wr_addr, e.addr);
            chk("wr_data", bus.mem_wr_data, e.d0);
            chk("wr_data_shift4", bus4.mem_wr_data, e.d4);
            chk("wr_width", bus.mem_wr_width, 1);
          end
          prev_last_wr = (bus.mem_wr_addr == 16'(N - 1));
        end
        if (start && !abort) begin
          exp_addr = 0;
          done_count = 0;
          wr_count = 0;
          q.delete();
        end
        if (abort) begin
          q.delete();
        end else if (bus.adc_valid && bus.adc_ready) begin
          q.push_back('{addr: 16'(exp_addr), d0: tb_exp0, d4: tb_exp4});
          exp_addr++;
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Offer n samples with given grant / valid percentages; returns at posedge+1
  // right after the edge that captured the n-th sample, with valid dropped.
  task automatic stream(input int n, input int gnt_pct, input int val_pct);
    int got;
    int guard;
    got = 0;
    guard = 0;
    while (got < n && guard < n * 10 + 100) begin
      @(posedge clk); #1;
      bus.mem_wr_gnt = ($urandom_range(99) < gnt_pct);
      bus.adc_valid  = ($urandom_range(99) < val_pct);
      bus.adc_data   = cur_adc;
      tb_exp0        = conv(cur_adc, 0);
      tb_exp4        = conv(cur_adc, 4);
      @(negedge clk);
      if (bus.adc_valid && bus.adc_ready) begin
        got++;
        last_acc = cur_adc;
        cur_adc  = 16'($urandom);
      end
      guard++;
    end
    chk("stream_budget", (got == n), 1);
    @(posedge clk); #1 bus.adc_valid = 1'b0;
  endtask

  task automatic finish_epoch(input string name, input logic exp_ovr);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 500 && !seen; k++) begin
      @(negedge clk);
      seen = done0;
    end
    chk({name, "_done_seen"}, seen, 1);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, done0, 0);
    chk({name, "_busy_low"}, busy0, 0);
    chk({name, "_done_count"}, done_count, 1);
    chk({name, "_wr_count"}, wr_count, N);
    chk({name, "_overrun"}, ovr0, exp_ovr);
    chk({name, "_queue_empty"}, q.size(), 0);
    $display("epoch %s: writes=%0d done=%0d overrun=%0d", name, wr_count, done_count, ovr0);
  endtask

  initial begin
    int k;
    vecs[0] = '{adc: 16'h0000, exp0: 16'h8000, exp4: 16'hF800};
    vecs[1] = '{adc: 16'h8000, exp0: 16'h0000, exp4: 16'h0000};
    vecs[2] = '{adc: 16'hFFFF, exp0: 16'h7FFF, exp4: 16'h07FF};
    vecs[3] = '{adc: 16'h1234, exp0: 16'h9234, exp4: 16'hF923};
    vecs[4] = '{adc: 16'h7FFF, exp0: 16'hFFFF, exp4: 16'hFFFF};
    vecs[5] = '{adc: 16'h8001, exp0: 16'h0001, exp4: 16'h0000};
    vecs[6] = '{adc: 16'hC000, exp0: 16'h4000, exp4: 16'h0400};

    bus.adc_data   = 16'h0;
    bus.adc_valid  = 1'b0;
    bus.mem_wr_gnt = 1'b0;
    cur_adc        = 16'($urandom);

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.adc_ready, 0);
    chk("rst_req", bus.mem_wr_req, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_overrun", ovr0, 0);
    chk("rst_addr", bus.mem_wr_addr, 16'h0000);
    chk("rst_data", bus.mem_wr_data, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;

    // Samples in IDLE are refused and do not flag overrun
    @(posedge clk); #1 bus.adc_valid = 1'b1;
    @(negedge clk);
    chk("idle_ready", bus.adc_ready, 0);
    @(posedge clk); #1 bus.adc_valid = 1'b0;
    @(negedge clk);
    chk("idle_no_overrun", ovr0, 0);

    // Epoch A: conversion table, then back-to-back with gnt tied high
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      bus.adc_valid  = 1'b1;
      bus.mem_wr_gnt = 1'b1;
      bus.adc_data   = vecs[i].adc;
      tb_exp0        = vecs[i].exp0;
      tb_exp4        = vecs[i].exp4;
      k = 0;
      @(negedge clk);
      while (!(bus.adc_valid && bus.adc_ready) && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("vec_accept", (k < 20), 1);
      @(posedge clk); #1 bus.adc_valid = 1'b0;
      @(negedge clk);
      chk("vec_req", bus.mem_wr_req, 1);
      chk("vec_data", bus.mem_wr_data, vecs[i].exp0);
      chk("vec_data_shift4", bus4.mem_wr_data, vecs[i].exp4);
      $display("vector adc=0x%04h data=0x%04h data_shift4=0x%04h", vecs[i].adc, bus.mem_wr_data, bus4.mem_wr_data);
    end
    stream(N - 7, 100, 100);
    finish_epoch("A", 1'b0);

    // Epoch B: grant stall on sample 10, then random grant/valid
    pulse_start();
    stream(11, 100, 100);
    bus.mem_wr_gnt = 1'b0;
    bus.adc_valid  = 1'b1;
    bus.adc_data   = cur_adc;
    tb_exp0        = conv(cur_adc, 0);
    tb_exp4        = conv(cur_adc, 4);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_req", bus.mem_wr_req, 1);
      chk("stall_addr", bus.mem_wr_addr, 16'd10);
      chk("stall_data", bus.mem_wr_data, conv(last_acc, 0));
      chk("stall_ready", bus.adc_ready, 0);
    end
    chk("stall_overrun", ovr0, 1);
    stream(N - 11, 30, 60);
    finish_epoch("B", 1'b1);

    // Epoch C: abort at sample 2000 with its write pending
    pulse_start();
    @(negedge clk);
    chk("start_clears_overrun", ovr0, 0);
    stream(2001, 30, 100);
    bus.mem_wr_gnt = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_ready", bus.adc_ready, 0);
    chk("abort_req_still_up", bus.mem_wr_req, 1);
    chk("abort_overrun_seen", ovr0, 1);
    @(posedge clk); #1;
    abort = 1'b0;
    bus.mem_wr_gnt = 1'b1;
    @(negedge clk);
    chk("abort_req_dropped", bus.mem_wr_req, 0);
    chk("abort_busy", busy0, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_count, 0);
    chk("abort_wr_count", wr_count, 2000);
    $display("epoch C: aborted after writes=%0d", wr_count);

    // Epoch D: restart at addr 0, then reset while draining
    pulse_start();
    @(negedge clk);
    chk("restart_overrun_cleared", ovr0, 0);
    stream(N, 100, 100);
    bus.mem_wr_gnt = 1'b0;
    @(negedge clk);
    chk("drain_busy", busy0, 1);
    chk("drain_req", bus.mem_wr_req, 1);
    chk("drain_addr", bus.mem_wr_addr, 16'(N - 1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", bus.adc_ready, 0);
    chk("async_rst_req", bus.mem_wr_req, 0);
    chk("async_rst_busy", busy0, 0);
    chk("async_rst_done", done0, 0);
    chk("async_rst_addr", bus.mem_wr_addr, 16'h0000);
    chk("async_rst_data", bus.mem_wr_data, 16'h0000);
    chk("async_rst_done_count", done_count, 0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_no_done", done_count, 0);
    $display("epoch D: reset during drain");

    // Epoch E: normal epoch after reset
    pulse_start();
    stream(N, 100, 100);
    finish_epoch("E", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
